// File: rtl/apb_pkg.sv
// apb_pkg: definitions shared by the APB4 requester bridge and its helpers.
//   apb_state_e       : bus FSM states (IDLE, SETUP, ACCESS)
//   DEF_*_WIDTH       : default address/data widths
//   PPROT_*           : bit positions within PPROT/SPROT
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;

  localparam int PPROT_PRIV    = 0;  // 1 = privileged access
  localparam int PPROT_NONSEC  = 1;  // 1 = non-secure access
  localparam int PPROT_INSTR   = 2;  // 1 = instruction fetch

endpackage

// File: rtl/apb_timeout_counter.sv
// apb_timeout_counter: wait-state watchdog for the ACCESS phase.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_access  : FSM is in ACCESS this cycle
//   pready     : slave ready
//   expired    : limit reached with PREADY still low; abort on the next edge
module apb_timeout_counter #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic in_access,
  input  logic pready,
  output logic expired
);

  logic [7:0] cnt;

  // Held at zero outside ACCESS, so every ACCESS entry starts from zero.
  always_ff @(posedge clk) begin
    if (rst || !in_access) begin
      cnt <= 8'd0;
    end else if (!pready) begin
      cnt <= cnt + 8'd1;
    end
  end

  // A ready slave on the limit cycle takes priority over the abort.
  assign expired = in_access && !pready && (cnt == 8'(LIMIT));

endmodule

// File: rtl/apb4_master_bridge.sv
// apb4_master_bridge: turns single-cycle requests into APB4 SETUP/ACCESS
// cycles and returns a one-cycle response pulse per completed transfer.
//
// Optional feature: define APB_TIMEOUT_EN to abort ACCESS phases that wait
// longer than TIMEOUT_CYCLES (STIMEOUT reports the abort). Without it,
// STIMEOUT is tied to 0 and ACCESS waits indefinitely.
//
// Ports:
//   PCLK, PRESET          : clock, synchronous active-high reset
//   transfer, S*          : request side (SWRITE/SADDR/SWDATA/SSTRB/SPROT)
//   busy                  : request cannot be accepted this cycle
//   P*                    : APB4 requester bus
//   SRVALID/SRDATA/SSLVERR/STIMEOUT : response
//   dbg_state             : current FSM state (apb_state_e encoding)
//
// Handshake: a request is accepted on any rising edge where transfer=1 and
// busy=0; transfer while busy=1 is ignored (not held, not queued).
module apb4_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    transfer,
  input  logic                    SWRITE,
  input  logic [ADDR_WIDTH-1:0]   SADDR,
  input  logic [DATA_WIDTH-1:0]   SWDATA,
  input  logic [DATA_WIDTH/8-1:0] SSTRB,
  input  logic [2:0]              SPROT,
  output logic                    busy,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [2:0]              PPROT,
  input  logic                    PREADY,
  input  logic                    PSLVERR,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    SRVALID,
  output logic [DATA_WIDTH-1:0]   SRDATA,
  output logic                    SSLVERR,
  output logic                    STIMEOUT,
  output logic [1:0]              dbg_state
);

  localparam logic [1:0] S_IDLE   = 2'(IDLE);
  localparam logic [1:0] S_SETUP  = 2'(SETUP);
  localparam logic [1:0] S_ACCESS = 2'(ACCESS);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  logic [1:0] state, state_nxt;
  logic       accept, complete, abort;

  assign busy      = (state == S_SETUP) || (state == S_ACCESS && !PREADY);
  assign accept    = transfer && !busy;
  assign complete  = (state == S_ACCESS) && PREADY;
  assign dbg_state = state;

`ifdef APB_TIMEOUT_EN
  apb_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk       (PCLK),
    .rst       (PRESET),
    .in_access (state == S_ACCESS),
    .pready    (PREADY),
    .expired   (abort)
  );

  // Follows the response that completes the transfer.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      STIMEOUT <= 1'b0;
    end else if (complete) begin
      STIMEOUT <= 1'b0;
    end else if (abort) begin
      STIMEOUT <= 1'b1;
    end
  end
`else
  assign abort    = 1'b0;
  assign STIMEOUT = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_SETUP;
      S_SETUP:  state_nxt = S_ACCESS;
      S_ACCESS: begin
        // accept can only be high here when PREADY=1 (back-to-back).
        if (PREADY)     state_nxt = accept ? S_SETUP : S_IDLE;
        else if (abort) state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= S_IDLE;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      PSTRB   <= '0;
      PPROT   <= '0;
      SRVALID <= 1'b0;
      SRDATA  <= '0;
      SSLVERR <= 1'b0;
    end else begin
      state   <= state_nxt;
      // Bus strobes are decoded from the next state so they are registered.
      PSEL    <= (state_nxt != S_IDLE);
      PENABLE <= (state_nxt == S_ACCESS);
      // Capture only at acceptance; busy blocks it during SETUP/wait states,
      // which keeps the bus fields stable for the whole transfer.
      if (accept) begin
        PWRITE <= SWRITE;
        PADDR  <= SADDR;
        PWDATA <= SWDATA;
        PSTRB  <= SWRITE ? SSTRB : '0;
        PPROT  <= SPROT;
      end
      SRVALID <= complete || abort;
      if (complete) begin
        SRDATA  <= PWRITE ? '0 : PRDATA;
        SSLVERR <= PSLVERR;
      end else if (abort) begin
        SRDATA  <= '0;
        SSLVERR <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb4_master_bridge.sv
// tb_apb4_master_bridge: directed bench for apb4_master_bridge. Responses are
// checked against an expected queue filled when each request is driven; bus
// timing is checked cycle by cycle in the main sequence.
module tb_apb4_master_bridge;
  import apb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int EW = DW + 2;  // {timeout, err, data}

  logic          PCLK, PRESET, transfer, SWRITE;
  logic [AW-1:0] SADDR;
  logic [DW-1:0] SWDATA;
  logic [SW-1:0] SSTRB;
  logic [2:0]    SPROT;
  logic          busy, PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [SW-1:0] PSTRB;
  logic [2:0]    PPROT;
  logic          PREADY, PSLVERR;
  logic [DW-1:0] PRDATA;
  logic          SRVALID, SSLVERR, STIMEOUT;
  logic [DW-1:0] SRDATA;
  logic [1:0]    dbg_state;

  apb4_master_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .SWRITE(SWRITE),
    .SADDR(SADDR), .SWDATA(SWDATA), .SSTRB(SSTRB), .SPROT(SPROT),
    .busy(busy), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA),
    .SRVALID(SRVALID), .SRDATA(SRDATA), .SSLVERR(SSLVERR),
    .STIMEOUT(STIMEOUT), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_exp    = 0;
  int n_resp   = 0;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic expect_resp(input logic to, input logic err, input logic [DW-1:0] d);
    exp_q.push_back({to, err, d});
    n_exp++;
  endtask

  always @(negedge PCLK) begin : monitor
    logic [EW-1:0] e;
    if (SRVALID === 1'b1) begin
      n_resp++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $error("FAIL unexpected_srvalid: observed a response, expected none");
      end else begin
        e = exp_q.pop_front();
        chk("srdata",   SRDATA,   e[DW-1:0]);
        chk("sslverr",  SSLVERR,  e[DW]);
        chk("stimeout", STIMEOUT, e[DW+1]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [SW-1:0] s, input logic [2:0] p);
    transfer = 1'b1;
    SWRITE   = wr;
    SADDR    = a;
    SWDATA   = d;
    SSTRB    = s;
    SPROT    = p;
  endtask

  // Scramble request fields while idle so bus stability is actually exercised.
  task automatic idle_req();
    transfer = 1'b0;
    SWRITE   = 1'($urandom_range(0, 1));
    SADDR    = $urandom;
    SWDATA   = $urandom;
    SSTRB    = SW'($urandom_range(0, (1 << SW) - 1));
    SPROT    = 3'($urandom_range(0, 7));
  endtask

  // ---------------- directed sequence ----------------
  logic [2:0] prot_rd;

  initial begin
    PRESET = 1'b1; PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = '0;
    idle_req();
    prot_rd = 3'b000;
    prot_rd[PPROT_PRIV]   = 1'b1;
    prot_rd[PPROT_NONSEC] = 1'b1;

    repeat (3) step();
    settle();
    chk("reset_ctrl", {PSEL, PENABLE, PWRITE, SRVALID, SSLVERR, STIMEOUT, busy}, 7'b0);
    chk("reset_paddr",  PADDR,  0);
    chk("reset_pwdata", PWDATA, 0);
    chk("reset_misc",   {PSTRB, PPROT, SRDATA}, 0);
    chk("reset_state",  dbg_state, IDLE);
    PRESET = 1'b0;
    step();

    // Zero-wait write
    step(); req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000); PREADY = 1'b1; settle();
    chk("w0_c0_busy", busy, 0);
    expect_resp(1'b0, 1'b0, 32'h0);
    step(); idle_req(); settle();
    chk("w0_c1_bus", {PSEL, PENABLE, busy, PWRITE}, 4'b1011);
    chk("w0_c1_paddr",  PADDR,  32'h10);
    chk("w0_c1_pwdata", PWDATA, 32'hDEADBEEF);
    chk("w0_c1_pstrb",  PSTRB,  4'hF);
    step(); settle();
    chk("w0_c2_bus", {PSEL, PENABLE, SRVALID}, 3'b110);
    step(); settle();
    chk("w0_c3_bus", {PSEL, PENABLE, SRVALID}, 3'b001);

    // Read with 3 wait states, read strobes forced to zero
    step(); req(1'b0, 32'h10, 32'h11111111, 4'hF, prot_rd); PREADY = 1'b0;
    PRDATA = 32'h12345678; settle();
    expect_resp(1'b0, 1'b0, 32'hDEADBEEF);
    step(); idle_req(); settle();
    chk("r3_c1_busy", busy, 1);
    chk("r3_c1_pstrb", PSTRB, 0);
    chk("r3_c1_ctl", {PWRITE, PPROT}, {1'b0, prot_rd});
    for (int i = 0; i < 3; i++) begin
      step(); settle();
      chk("r3_wait_bus", {busy, PSEL, PENABLE, SRVALID}, 4'b1110);
      chk("r3_wait_paddr", PADDR, 32'h10);
    end
    step(); PREADY = 1'b1; PRDATA = 32'hDEADBEEF; settle();
    chk("r3_c5_busy", busy, 0);
    step(); PRDATA = 32'h0; settle();
    chk("r3_c6_resp", {SRVALID, PSEL}, 2'b10);

    // Back-to-back: write 0x4 then read 0x8
    step(); req(1'b1, 32'h4, 32'hA5A50004, 4'h3, 3'b000); PREADY = 1'b1; settle();
    expect_resp(1'b0, 1'b0, 32'h0);
    step(); req(1'b0, 32'h8, 32'h0, 4'hF, 3'b001); settle();  // ignored: busy
    chk("b2b_c1", {PSEL, PENABLE}, 2'b10);
    chk("b2b_c1_paddr", PADDR, 32'h4);
    step(); PRDATA = 32'h00000B0B; settle();                  // accepted here
    chk("b2b_c2", {PSEL, PENABLE, busy}, 3'b110);
    chk("b2b_c2_paddr", PADDR, 32'h4);
    expect_resp(1'b0, 1'b0, 32'hCAFE0008);
    step(); idle_req(); settle();
    chk("b2b_c3", {PSEL, PENABLE, SRVALID, PWRITE}, 4'b1010);
    chk("b2b_c3_paddr", PADDR, 32'h8);
    step(); PRDATA = 32'hCAFE0008; settle();
    chk("b2b_c4", {PSEL, PENABLE, SRVALID}, 3'b110);
    step(); PRDATA = 32'h0; settle();
    chk("b2b_c5", {PSEL, SRVALID}, 2'b01);

    // Slave error, then a clean transfer with PSLVERR high only during SETUP
    step(); req(1'b1, 32'hFFFF_FFF0, 32'h0BAD0BAD, 4'h3, 3'b000); PSLVERR = 1'b1; settle();
    expect_resp(1'b0, 1'b1, 32'h0);
    step(); idle_req();
    step();
    step(); req(1'b0, 32'h20, 32'h0, 4'h0, 3'b000); settle();
    chk("err_c3_resp", SRVALID, 1);
    expect_resp(1'b0, 1'b0, 32'h5A5A0020);
    step(); idle_req(); settle();
    chk("err_hold", {SRVALID, SSLVERR}, 2'b01);
    step(); PSLVERR = 1'b0; PRDATA = 32'h5A5A0020;
    step(); settle();
    chk("err_next_resp", SRVALID, 1);

    // Reset during a waiting ACCESS: no response for the aborted transfer
    step(); req(1'b0, 32'h30, 32'h0, 4'h0, 3'b000); PREADY = 1'b0; settle();
    step(); idle_req();
    step(); settle();
    chk("rst_c2_pen", PENABLE, 1);
    PRESET = 1'b1;
    step(); PRESET = 1'b0; settle();
    chk("rst_c3_bus", {PSEL, PENABLE, busy, SRVALID}, 4'b0);
    chk("rst_c3_state", dbg_state, IDLE);
    PREADY = 1'b1;
    repeat (3) step();

`ifdef APB_TIMEOUT_EN
    // Watchdog abort at the limit; a request on the abort cycle is refused
    step(); req(1'b0, 32'h40, 32'h0, 4'h0, 3'b000); PREADY = 1'b0; PRDATA = 32'hFFFFFFFF;
    expect_resp(1'b1, 1'b1, 32'h0);
    step(); idle_req();
    for (int i = 0; i < 4; i++) begin
      step(); settle();
      chk("to_wait", {PSEL, PENABLE}, 2'b11);
    end
    step(); req(1'b1, 32'h50, 32'h1, 4'h1, 3'b000); settle();   // limit cycle
    chk("to_limit_busy", busy, 1);
    step(); idle_req(); settle();
    chk("to_abort", {PSEL, PENABLE, SRVALID, STIMEOUT}, 4'b0011);
    chk("to_abort_state", dbg_state, IDLE);

    // PREADY on the limit cycle completes normally
    step(); req(1'b0, 32'h44, 32'h0, 4'h0, 3'b000); PREADY = 1'b0;
    expect_resp(1'b0, 1'b0, 32'h600D0044);
    step(); idle_req();
    repeat (4) step();
    step(); PREADY = 1'b1; PRDATA = 32'h600D0044;
    step(); settle();
    chk("to_limit_ok", {SRVALID, STIMEOUT}, 2'b10);
`else
    // No watchdog: ACCESS keeps waiting
    step(); req(1'b0, 32'h48, 32'h0, 4'h0, 3'b000); PREADY = 1'b0;
    expect_resp(1'b0, 1'b0, 32'h77770048);
    step(); idle_req();
    repeat (20) step();
    settle();
    chk("nowd_still_access", dbg_state, ACCESS);
    step(); PREADY = 1'b1; PRDATA = 32'h77770048;
    step(); settle();
    chk("nowd_resp", SRVALID, 1);
`endif

    PREADY = 1'b1;
    repeat (4) step();
    chk("queue_drained", exp_q.size(), 0);
    chk("resp_count", n_resp, n_exp);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
